score_bcd: RTL and testbench
============================

// Module: score_bcd
// PURPOSE
//  Sequential binary-to-BCD converter for the game score. Sits between jumplogic (binary Score)
//  and the HexDriver instances on HEX5..HEX3. Converts once per frame (VGA_VS rising edge) via
//  shift-add-3 (double dabble), one bit per Clk, and holds a stable digit vector in between.
// PARAMETERS
//  BIN_W   12  width of binary Score input
//  DIGITS  3   BCD digits produced; saturation limit = 10^DIGITS-1 (999 at default)
// PORTS
//  Clk        in   1               system clock (MAX10_CLK1_50); single clock domain
//  Reset_n    in   1               asynchronous, active-low reset
//  frame_clk  in   1               VGA_VS; asynchronous to Clk, synchronised internally
//  Clear      in   1               synchronous game-restart: abort conversion, zero Digits
//  Score      in   BIN_W           binary score from jumplogic
//  Digits     out  4*DIGITS        BCD result, digit 0 in [3:0]
//  Valid      out  1               1-cycle pulse when Digits updates
//  Busy       out  1               high during LOAD/SHIFT/DONE
//  Overflow   out  1               Score > 10^DIGITS-1 on last conversion
//  HiDigits   out  4*DIGITS        best score in BCD (HIGH_SCORE_EN only)
//  NewHigh    out  1               1-cycle pulse when HiDigits updates (HIGH_SCORE_EN only)
// BEHAVIOUR
//  - Reset (async, Reset_n=0): state IDLE; Digits, HiDigits, Overflow, Valid, NewHigh, Busy = 0;
//    sync flops and pending flag cleared. Reset mid-conversion discards all partial work.
//  - frame_clk: 2-flop synchroniser + edge register; start request = rising edge, 1 Clk wide.
//  - FSM: IDLE -(start)-> LOAD -> SHIFT (BIN_W cycles) -> DONE -> IDLE.
//    LOAD: capture Score into shift reg, zero BCD accumulator, bit counter = BIN_W-1.
//    SHIFT: each cycle add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
//    DONE: if captured Score > 10^DIGITS-1 -> Digits = all 9s, Overflow=1; else Digits = acc,
//    Overflow=0. Valid pulses this cycle.
//  - Latency: Digits valid BIN_W+2 Clk after start (14 at default); start is 3 Clk after edge.
//  - Accumulator internally one nibble wider than DIGITS to detect overflow; not exported.
//  - Start while Busy: set one pending flag (further starts coalesce); DONE->LOAD directly if set.
//  - Clear: highest priority after reset; state->IDLE, pending=0, Digits=0, Overflow=0, no
//    Valid. Clear and start in same cycle: Clear wins, start dropped.
//  - Score changing mid-conversion has no effect; value captured at LOAD is converted.
//  - Digits/Overflow change only in DONE (or Clear); stable otherwise.
// CONFIGURATION
//  - SCORE_BCD_HIGH_SCORE_EN defined: HiDigits register; in DONE, if result (post-saturation)
//    > HiDigits, HiDigits <= result, NewHigh pulses with Valid. Clear does NOT reset HiDigits;
//    only Reset_n does.
//  - Not defined: HiDigits tied to 0, NewHigh tied to 0, no compare logic.
// STRUCTURE
//  - score_pkg: state enum {S_IDLE,S_LOAD,S_SHIFT,S_DONE}; typedef logic [3:0] bcd_t;
//    function max_bcd(DIGITS) returning all-9s vector; constant MAX_SCORE(DIGITS).
//  - Sub-module bcd_add3: combinational per-nibble (n>=5 ? n+3 : n), instantiated DIGITS+1 times
//    by generate loop. All state in score_bcd.
// TESTING
//  - Score=0, one frame_clk edge -> Valid after 17 Clk from edge, Digits=12'h000, Overflow=0.
//  - Score=12'd987 -> Digits=12'h987, Overflow=0; Score=12'd1000 -> Digits=12'h999, Overflow=1.
//  - Two edges 2 Clk apart, then third during SHIFT -> exactly two Valid pulses, back-to-back
//    conversions (second LOAD immediately after first DONE).
//  - Reset_n low at SHIFT cycle 5 with Score=456 -> all outputs 0 immediately; next edge gives 456.
//  - Clear asserted same cycle as start with Digits=12'h123 -> Digits=0, no Valid, state IDLE.
//  - HIGH_SCORE_EN: scores 300,150,420 on successive frames -> HiDigits 300,300,420; NewHigh on
//    1st and 3rd; Clear leaves HiDigits=420.

Source files
------------

// File: rtl/score_bcd_pkg.sv
// Shared types and constants for the score binary-to-BCD converter.
package score_bcd_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

  typedef logic [3:0] bcd_t;

  // Widest digit count the helper functions support.
  localparam int unsigned MaxDigits = 8;

  // All-9s BCD vector for the given digit count, right-aligned in a MaxDigits-wide word.
  function automatic logic [4*MaxDigits-1:0] max_bcd(input int unsigned digits);
    logic [4*MaxDigits-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MaxDigits; i++) begin
      if (i < digits) v[4*i +: 4] = 4'h9;
    end
    return v;
  endfunction

  // Largest binary value representable in the given number of decimal digits.
  function automatic int unsigned max_score(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/score_bcd_if.sv
// Score converter bus: the game side drives Clear/Score, the converter returns digits and status.
interface score_bcd_if #(
  parameter int unsigned BIN_W  = 12,
  parameter int unsigned DIGITS = 3
);

  logic                  Clear;
  logic [BIN_W-1:0]      Score;
  logic [4*DIGITS-1:0]   Digits;
  logic                  Valid;
  logic                  Busy;
  logic                  Overflow;
  logic [4*DIGITS-1:0]   HiDigits;
  logic                  NewHigh;

  modport master (
    output Clear, Score,
    input  Digits, Valid, Busy, Overflow, HiDigits, NewHigh
  );

  modport slave (
    input  Clear, Score,
    output Digits, Valid, Busy, Overflow, HiDigits, NewHigh
  );

endinterface

// File: rtl/score_bcd_add3.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module score_bcd_add3
  import score_bcd_pkg::*;
(
  input  bcd_t nib,
  output bcd_t adj
);

  // A nibble of at most 9 becomes at most 12, so the sum stays within 4 bits.
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/score_bcd.sv
// Sequential binary-to-BCD converter for the game score. One conversion per frame_clk rising
// edge, one bit per Clk (shift-add-3), digits held stable between conversions.
// Optional best-score tracking is enabled by defining SCORE_BCD_HIGH_SCORE_EN.
module score_bcd
  import score_bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 12,
  parameter int unsigned DIGITS = 3
) (
  input  logic      Clk,
  input  logic      Reset_n,
  input  logic      frame_clk,
  score_bcd_if.slave bus
);

  localparam int unsigned AccW = 4 * (DIGITS + 1);
  localparam int unsigned OutW = 4 * DIGITS;
  localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [4*MaxDigits-1:0] MaxBcdAll = max_bcd(DIGITS);
  localparam logic [OutW-1:0]        MaxBcd    = MaxBcdAll[OutW-1:0];
  localparam int unsigned            MaxScore  = max_score(DIGITS);
  localparam logic [CntW-1:0]        CntInit   = CntW'(BIN_W - 1);

  logic fs_meta, fs_sync, fs_prev, start;

  state_e            state_q;
  logic              pend_q;
  logic [BIN_W-1:0]  bin_q;
  logic [AccW-1:0]   acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              sat_q;
  logic [OutW-1:0]   digits_q;
  logic              valid_q;
  logic              busy_q;
  logic              ovf_q;

  logic [AccW-1:0]   acc_adj;
  logic [AccW-1:0]   acc_shift;
  logic [BIN_W-1:0]  bin_shift;
  logic [OutW-1:0]   result;
  logic              last_shift;

  // Bring frame_clk into the Clk domain and turn its rising edge into a one-cycle start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs_meta <= 1'b0;
      fs_sync <= 1'b0;
      fs_prev <= 1'b0;
      start   <= 1'b0;
    end else begin
      fs_meta <= frame_clk;
      fs_sync <= fs_meta;
      fs_prev <= fs_sync;
      start   <= fs_sync & ~fs_prev;
    end
  end

  // The extra top nibble keeps the accumulator exact for any 12-bit score.
  for (genvar i = 0; i < DIGITS + 1; i++) begin : g_add3
    score_bcd_add3 u_add3 (
      .nib (acc_q[4*i +: 4]),
      .adj (acc_adj[4*i +: 4])
    );
  end

  assign acc_shift  = {acc_adj[AccW-2:0], bin_q[BIN_W-1]};
  assign bin_shift  = {bin_q[BIN_W-2:0], 1'b0};
  assign result     = sat_q ? MaxBcd : acc_shift[OutW-1:0];
  assign last_shift = (state_q == S_SHIFT) && (cnt_q == '0);

  // Conversion FSM; the result is committed on the final shift so it is visible during DONE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      bin_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      digits_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (bus.Clear) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      digits_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          bin_q   <= bus.Score;
          acc_q   <= '0;
          cnt_q   <= CntInit;
          sat_q   <= (32'(bus.Score) > MaxScore);
          state_q <= S_SHIFT;
          if (start) pend_q <= 1'b1;
        end
        S_SHIFT: begin
          bin_q <= bin_shift;
          acc_q <= acc_shift;
          cnt_q <= cnt_q - CntW'(1);
          if (start) pend_q <= 1'b1;
          if (last_shift) begin
            state_q  <= S_DONE;
            digits_q <= result;
            ovf_q    <= sat_q;
            valid_q  <= 1'b1;
          end
        end
        S_DONE: begin
          // A start seen while busy (or right now) chains straight into the next load.
          if (pend_q || start) begin
            state_q <= S_LOAD;
            pend_q  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.Digits   = digits_q;
  assign bus.Valid    = valid_q;
  assign bus.Busy     = busy_q;
  assign bus.Overflow = ovf_q;

`ifdef SCORE_BCD_HIGH_SCORE_EN
  logic [OutW-1:0] hi_q;
  logic            new_high_q;

  // Track the best committed result; only Reset_n clears it, not the game-restart Clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hi_q       <= '0;
      new_high_q <= 1'b0;
    end else begin
      new_high_q <= 1'b0;
      if (!bus.Clear && last_shift && (result > hi_q)) begin
        hi_q       <= result;
        new_high_q <= 1'b1;
      end
    end
  end

  assign bus.HiDigits = hi_q;
  assign bus.NewHigh  = new_high_q;
`else
  assign bus.HiDigits = '0;
  assign bus.NewHigh  = 1'b0;
`endif

endmodule

// File: tb/tb_score_bcd.sv
// Self-checking bench for score_bcd: directed corner cases plus random scores against a
// decimal reference model.
module tb_score_bcd;

  localparam int unsigned BIN_W    = 12;
  localparam int unsigned DIGITS   = 3;
  localparam int unsigned OutW     = 4 * DIGITS;
  localparam int unsigned MaxScore = 999;
`ifdef SCORE_BCD_HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic Clk;
  logic Reset_n;
  logic frame_clk;

  int checks;
  int errors;

  int unsigned     hi_val;
  logic [OutW-1:0] exp_prev;

  score_bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  score_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Decimal digits of v, least significant digit in the low nibble.
  function automatic logic [OutW-1:0] to_bcd(input int unsigned v);
    logic [OutW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("rst_digits", bus.Digits, 0);
    check("rst_valid", bus.Valid, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_ovf", bus.Overflow, 0);
    check("rst_hi", bus.HiDigits, 0);
    @(negedge Clk);
    Reset_n  = 1'b1;
    hi_val   = 0;
    exp_prev = '0;
  endtask

  // One frame: pulse frame_clk, wait for Valid, compare against the decimal model.
  task automatic convert(input int unsigned score);
    int unsigned     v;
    int              lat;
    logic [OutW-1:0] exp_d;
    bit              exp_ovf;
    bit              exp_nh;
    v       = (score > MaxScore) ? MaxScore : score;
    exp_d   = to_bcd(v);
    exp_ovf = (score > MaxScore);
    exp_nh  = HS && (v > hi_val);
    @(negedge Clk);
    bus.Score = BIN_W'(score);
    frame_clk = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (i == 1) frame_clk = 1'b0;
      // Captured value must be used, not the live input.
      if (i == 8) bus.Score = BIN_W'($urandom);
      if (i == 16) check("digits_hold", bus.Digits, exp_prev);
      if (bus.Valid) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, 17);
    check("digits", bus.Digits, exp_d);
    check("overflow", bus.Overflow, exp_ovf);
    check("new_high", bus.NewHigh, exp_nh);
    if (v > hi_val) hi_val = v;
    check("hi_digits", bus.HiDigits, HS ? to_bcd(hi_val) : '0);
    @(negedge Clk);
    check("busy_end", bus.Busy, 0);
    check("valid_pulse", bus.Valid, 0);
    exp_prev = exp_d;
  endtask

  initial begin
    int n_valid;
    int t1;
    int t2;
    int busy_seen;
    checks    = 0;
    errors    = 0;
    hi_val    = 0;
    exp_prev  = '0;
    Reset_n   = 1'b1;
    frame_clk = 1'b0;
    bus.Clear = 1'b0;
    bus.Score = '0;
    #2;
    do_reset();

    // Directed values including the saturation boundary.
    convert(0);
    convert(987);
    convert(1000);
    convert(999);
    convert(4095);

    for (int k = 0; k < 20; k++) convert($urandom_range(0, 1200));

    // Two edges 2 Clk apart, then a third during SHIFT: two back-to-back conversions.
    @(negedge Clk);
    bus.Score = BIN_W'(111);
    frame_clk = 1'b1;
    n_valid = 0;
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge Clk);
      if (i == 1 || i == 3 || i == 11) frame_clk = 1'b0;
      if (i == 2 || i == 10) frame_clk = 1'b1;
      if (bus.Valid) begin
        n_valid++;
        if (n_valid == 1) t1 = i;
        else t2 = i;
      end
    end
    check("b2b_count", n_valid, 2);
    check("b2b_gap", t2 - t1, BIN_W + 2);
    check("b2b_digits", bus.Digits, 12'h111);
    check("b2b_busy", bus.Busy, 0);
    if (111 > hi_val) hi_val = 111;
    exp_prev = 12'h111;

    // Reset in the middle of a conversion discards it.
    @(negedge Clk);
    bus.Score = BIN_W'(456);
    frame_clk = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      if (i == 1) frame_clk = 1'b0;
    end
    check("midrst_busy_before", bus.Busy, 1);
    Reset_n = 1'b0;
    #1;
    check("midrst_digits", bus.Digits, 0);
    check("midrst_busy", bus.Busy, 0);
    check("midrst_valid", bus.Valid, 0);
    check("midrst_hi", bus.HiDigits, 0);
    @(negedge Clk);
    Reset_n  = 1'b1;
    hi_val   = 0;
    exp_prev = '0;
    convert(456);

    // Clear coinciding with start: Clear wins, nothing converts.
    convert(123);
    @(negedge Clk);
    bus.Score = BIN_W'(777);
    frame_clk = 1'b1;
    n_valid = 0;
    busy_seen = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clk);
      if (i == 1) frame_clk = 1'b0;
      if (i == 3) bus.Clear = 1'b1;
      if (i == 4) bus.Clear = 1'b0;
      if (bus.Valid) n_valid++;
      if (bus.Busy) busy_seen++;
    end
    check("clr_valid", n_valid, 0);
    check("clr_busy", busy_seen, 0);
    check("clr_digits", bus.Digits, 0);
    check("clr_ovf", bus.Overflow, 0);
    exp_prev = '0;

    // Best-score tracking across frames; Clear must leave it intact.
    do_reset();
    convert(300);
    convert(150);
    convert(420);
    @(negedge Clk);
    bus.Clear = 1'b1;
    @(negedge Clk);
    bus.Clear = 1'b0;
    check("hi_after_clear", bus.HiDigits, HS ? 12'h420 : 12'h000);
    check("digits_after_clear", bus.Digits, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
